// File: rtl/bus_burst_sram_slave.sv
// bus_burst_sram_slave
// Bus-side burst slave backed by a word-organised SRAM. It decodes a window
// of 2^addressBits 32-bit words starting at baseAddress. Read bursts are
// streamed out one word per beat. Write bursts are absorbed under per-byte
// enables.
//
// Build option: define SLAVE_WAIT_STATE_EN to insert an idle cycle between
// read beats and to drive an alternating busyOut during write bursts.
//
// Handshake summary:
// - A transaction is accepted only on beginTransactionIn while IDLE with an
//   in-window address.
// - A write beat is consumed on a clock edge where dataValidIn=1 and the
//   registered busyOut=0. The master holds the beat while busyOut=1.
// - A read beat is valid on each cycle with dataValidOut=1.
//   endTransactionOut marks the cycle after the last beat.
// - All outputs are registered and are 0 in IDLE, so several slaves can be
//   OR-combined onto one return bus.
module bus_burst_sram_slave #(
    parameter logic [31:0] baseAddress = 32'h40000000,
    parameter int          addressBits = 10
) (
    input  logic        clock,
    input  logic        reset,              // active-low, asynchronous
    input  logic        beginTransactionIn,
    input  logic [31:0] addressDataIn,
    input  logic        readNotWriteIn,
    input  logic [3:0]  byteEnablesIn,
    input  logic [7:0]  burstSizeIn,
    input  logic        dataValidIn,
    input  logic        endTransactionIn,
    output logic [31:0] addressDataOut,
    output logic        dataValidOut,
    output logic        endTransactionOut,
    output logic        busErrorOut,
    output logic        busyOut,
    output logic [2:0]  debugStateOut       // current FSM state, for observation
);

    // FSM encoding; IDLE must stay 0 so the debug output is 0 when idle.
    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_RD_SETUP = 3'd1;
    localparam logic [2:0] S_RD_BURST = 3'd2;
    localparam logic [2:0] S_RD_END   = 3'd3;
    localparam logic [2:0] S_WR_BURST = 3'd4;
    localparam logic [2:0] S_ERR      = 3'd5;

    localparam int          NUM_WORDS = 1 << addressBits;
    localparam logic [31:0] WIN_BYTES = 32'd4 << addressBits;
    localparam logic [31:0] LAST_WORD = (32'd1 << addressBits) - 32'd1;
    localparam logic [addressBits-1:0] ADDR_ONE = {{(addressBits-1){1'b0}}, 1'b1};

`ifdef SLAVE_WAIT_STATE_EN
    localparam logic WAIT_EN = 1'b1;
`else
    localparam logic WAIT_EN = 1'b0;
`endif

    // Storage; deliberately not reset so contents survive a bus reset.
    logic [31:0] r_mem [0:NUM_WORDS-1];

    // Transaction context latched at begin.
    logic [2:0]             r_state;
    logic [addressBits-1:0] r_addr;
    logic [7:0]             r_cnt;      // beats still to go after the current one
    logic [3:0]             r_be;
    logic                   r_rnw;
    logic                   r_wdone;    // write burst has received all its beats

    // Registered outputs.
    logic [31:0] r_data_out;
    logic        r_dv_out;
    logic        r_end_out;
    logic        r_err_out;
    logic        r_busy;

    // Decode and range check of the begin-cycle address.
    logic [31:0] w_offset;
    logic [31:0] w_word;
    logic [31:0] w_last;
    logic        w_hit;
    logic        w_range_err;
    logic        w_accept;
    logic        w_wr_fire;
    logic        w_rd_gap;

    // Offset arithmetic is modulo 2^32. Addresses below the base therefore
    // wrap to huge offsets and fail the window test.
    assign w_offset    = addressDataIn - baseAddress;
    assign w_word      = w_offset >> 2;
    assign w_last      = w_word + {24'd0, burstSizeIn};
    assign w_hit       = (w_offset < WIN_BYTES);
    assign w_range_err = (w_last > LAST_WORD);
    assign w_accept    = beginTransactionIn && (r_state == S_IDLE) && w_hit;

    // A write beat lands when it is offered, the slave is not stalling it,
    // and the burst still has room. Surplus beats are silently dropped.
    assign w_wr_fire = (r_state == S_WR_BURST) && dataValidIn && !r_busy && !r_wdone;

    // In the wait-state build, the cycle after each read beat is left empty.
    assign w_rd_gap = WAIT_EN && r_dv_out;

    // Control FSM, transaction context and registered bus outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_addr     <= '0;
            r_cnt      <= 8'd0;
            r_be       <= 4'd0;
            r_rnw      <= 1'b0;
            r_wdone    <= 1'b0;
            r_data_out <= 32'd0;
            r_dv_out   <= 1'b0;
            r_end_out  <= 1'b0;
            r_err_out  <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_data_out <= 32'd0;
                    r_dv_out   <= 1'b0;
                    r_end_out  <= 1'b0;
                    r_err_out  <= 1'b0;
                    r_busy     <= 1'b0;
                    if (w_accept) begin
                        r_addr  <= w_word[addressBits-1:0];
                        r_cnt   <= burstSizeIn;
                        r_be    <= byteEnablesIn;
                        r_rnw   <= readNotWriteIn;
                        r_wdone <= 1'b0;
                        if (w_range_err) begin
                            r_err_out <= 1'b1;
                            r_state   <= S_ERR;
                        end else if (readNotWriteIn) begin
                            r_state <= S_RD_SETUP;
                        end else begin
                            r_busy  <= WAIT_EN;
                            r_state <= S_WR_BURST;
                        end
                    end
                end

                // The SRAM read latency cycle; the first beat is registered here.
                S_RD_SETUP: begin
                    r_data_out <= r_mem[r_addr];
                    r_dv_out   <= 1'b1;
                    r_addr     <= r_addr + ADDR_ONE;
                    r_state    <= S_RD_BURST;
                end

                S_RD_BURST: begin
                    if (r_cnt == 8'd0) begin
                        // Last beat is on the bus now; close the burst next cycle.
                        r_data_out <= 32'd0;
                        r_dv_out   <= 1'b0;
                        r_end_out  <= 1'b1;
                        r_state    <= S_RD_END;
                    end else if (w_rd_gap) begin
                        r_data_out <= 32'd0;
                        r_dv_out   <= 1'b0;
                    end else begin
                        r_data_out <= r_mem[r_addr];
                        r_dv_out   <= 1'b1;
                        r_addr     <= r_addr + ADDR_ONE;
                        r_cnt      <= r_cnt - 8'd1;
                    end
                end

                S_RD_END: begin
                    r_end_out <= 1'b0;
                    r_state   <= S_IDLE;
                end

                S_WR_BURST: begin
                    if (w_wr_fire) begin
                        r_addr <= r_addr + ADDR_ONE;
                        if (r_cnt == 8'd0) begin
                            r_wdone <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt - 8'd1;
                        end
                    end
                    if (endTransactionIn) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_busy <= WAIT_EN & ~r_busy;
                    end
                end

                // Error pulse has been shown. A read is closed by the slave;
                // a write waits for the master to end it.
                S_ERR: begin
                    r_err_out <= 1'b0;
                    if (r_rnw) begin
                        r_end_out <= 1'b1;
                        r_state   <= S_RD_END;
                    end else if (endTransactionIn) begin
                        r_state <= S_IDLE;
                    end
                end

                default: begin
                    r_data_out <= 32'd0;
                    r_dv_out   <= 1'b0;
                    r_end_out  <= 1'b0;
                    r_err_out  <= 1'b0;
                    r_busy     <= 1'b0;
                    r_state    <= S_IDLE;
                end
            endcase
        end
    end

    // SRAM write port with per-byte lane enables latched at begin.
    always_ff @(posedge clock) begin
        if (w_wr_fire) begin
            for (int b = 0; b < 4; b++) begin
                if (r_be[b]) begin
                    r_mem[r_addr][8*b +: 8] <= addressDataIn[8*b +: 8];
                end
            end
        end
    end

    assign addressDataOut    = r_data_out;
    assign dataValidOut      = r_dv_out;
    assign endTransactionOut = r_end_out;
    assign busErrorOut       = r_err_out;
    assign busyOut           = r_busy;
    assign debugStateOut     = r_state;

endmodule

// File: tb/tb_bus_burst_sram_slave.sv
// Directed testbench for bus_burst_sram_slave (default parameters).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_bus_burst_sram_slave;

    localparam logic [31:0] BASE = 32'h40000000;

    localparam logic [31:0] ST_IDLE = 32'd0;
    localparam logic [31:0] ST_ERR  = 32'd5;

`ifdef SLAVE_WAIT_STATE_EN
    localparam int   STEP  = 2;
    localparam logic BUSY0 = 1'b1;
`else
    localparam int   STEP  = 1;
    localparam logic BUSY0 = 1'b0;
`endif

    // Clock and reset
    logic        clock = 1'b0;
    logic        reset;
    logic        beginTransactionIn;
    logic [31:0] addressDataIn;
    logic        readNotWriteIn;
    logic [3:0]  byteEnablesIn;
    logic [7:0]  burstSizeIn;
    logic        dataValidIn;
    logic        endTransactionIn;
    logic [31:0] addressDataOut;
    logic        dataValidOut;
    logic        endTransactionOut;
    logic        busErrorOut;
    logic        busyOut;
    logic [2:0]  debugStateOut;

    always #5 clock = ~clock;

    bus_burst_sram_slave dut (
        .clock              (clock),
        .reset              (reset),
        .beginTransactionIn (beginTransactionIn),
        .addressDataIn      (addressDataIn),
        .readNotWriteIn     (readNotWriteIn),
        .byteEnablesIn      (byteEnablesIn),
        .burstSizeIn        (burstSizeIn),
        .dataValidIn        (dataValidIn),
        .endTransactionIn   (endTransactionIn),
        .addressDataOut     (addressDataOut),
        .dataValidOut       (dataValidOut),
        .endTransactionOut  (endTransactionOut),
        .busErrorOut        (busErrorOut),
        .busyOut            (busyOut),
        .debugStateOut      (debugStateOut)
    );

    int          vectors     = 0;
    int          miscompares = 0;
    logic [31:0] wdata [0:15];
    logic [31:0] got   [0:15];
    int          got_n;

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check(tag, {28'd0, dataValidOut, endTransactionOut, busErrorOut, busyOut}, 32'd0);
        check({tag, "_data"}, addressDataOut, 32'd0);
        check({tag, "_state"}, {29'd0, debugStateOut}, ST_IDLE);
    endtask

    // Driver: presents a begin cycle and returns at the negedge of begin+1.
    task automatic begin_txn(input logic [31:0] addr, input logic rnw,
                             input logic [3:0] be, input logic [7:0] burst);
        beginTransactionIn = 1'b1;
        addressDataIn      = addr;
        readNotWriteIn     = rnw;
        byteEnablesIn      = be;
        burstSizeIn        = burst;
        tick();
        beginTransactionIn = 1'b0;
        addressDataIn      = 32'd0;
        readNotWriteIn     = 1'b0;
        byteEnablesIn      = 4'd0;
        burstSizeIn        = 8'd0;
    endtask

    // Driver: write burst from wdata[], holding each beat while busyOut=1.
    task automatic write_burst(input logic [31:0] addr, input logic [3:0] be,
                               input logic [7:0] burst, input int nbeats,
                               input logic end_with_last);
        int   i = 0;
        int   guard = 0;
        logic b;
        logic exp_busy = BUSY0;
        begin_txn(addr, 1'b0, be, burst);
        check("wr_no_err", {31'd0, busErrorOut}, 32'd0);
        while (i < nbeats && guard < 100) begin
            check("wr_busy", {31'd0, busyOut}, {31'd0, exp_busy});
            b                = busyOut;
            dataValidIn      = 1'b1;
            addressDataIn    = wdata[i];
            endTransactionIn = end_with_last && (i == nbeats - 1) && !b;
            tick();
            guard++;
            if (!b) i++;
            if (STEP == 2) exp_busy = ~exp_busy;
        end
        check("wr_guard", 32'(guard < 100), 32'd1);
        dataValidIn   = 1'b0;
        addressDataIn = 32'd0;
        if (!end_with_last) begin
            endTransactionIn = 1'b1;
            tick();
        end
        endTransactionIn = 1'b0;
        check_idle("wr_done_idle");
    endtask

    // Driver + monitor: read burst into got[], checking beat timing.
    task automatic read_burst(input logic [31:0] addr, input logic [7:0] burst);
        int   cyc = 1;
        int   last_cyc = 0;
        logic saw_end = 1'b0;
        got_n = 0;
        begin_txn(addr, 1'b1, 4'hF, burst);
        check("rd_no_err", {31'd0, busErrorOut}, 32'd0);
        check("rd_no_dv_b1", {31'd0, dataValidOut}, 32'd0);
        while (!saw_end && cyc < 200) begin
            tick();
            cyc++;
            if (dataValidOut) begin
                if (got_n == 0) check("rd_first_lat", 32'(cyc), 32'd2);
                else            check("rd_spacing", 32'(cyc - last_cyc), 32'(STEP));
                if (got_n < 16) got[got_n] = addressDataOut;
                got_n++;
                last_cyc = cyc;
            end
            if (endTransactionOut) begin
                saw_end = 1'b1;
                check("rd_end_after_last", 32'(cyc - last_cyc), 32'd1);
                check("rd_end_no_dv", {31'd0, dataValidOut}, 32'd0);
            end
        end
        check("rd_end_seen", {31'd0, saw_end}, 32'd1);
        check("rd_beats", 32'(got_n), 32'(burst) + 32'd1);
        tick();
        check_idle("rd_done_idle");
    endtask

    // Watchdog against a hung bench.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Directed stimulus
    initial begin
        int k;
        int guard;
        reset              = 1'b0;
        beginTransactionIn = 1'b0;
        addressDataIn      = 32'd0;
        readNotWriteIn     = 1'b0;
        byteEnablesIn      = 4'd0;
        burstSizeIn        = 8'd0;
        dataValidIn        = 1'b0;
        endTransactionIn   = 1'b0;
        tick();
        tick();
        check_idle("reset_hold");
        reset = 1'b1;
        tick();
        check_idle("after_reset");

        // Write burst of 4 words at word 4; end coincides with the last beat.
        wdata[0] = 32'hA0; wdata[1] = 32'hA1; wdata[2] = 32'hA2; wdata[3] = 32'hA3;
        write_burst(BASE + 32'h10, 4'hF, 8'd3, 4, 1'b1);
        read_burst(BASE + 32'h10, 8'd3);
        check("t1_w4", got[0], 32'hA0);
        check("t1_w5", got[1], 32'hA1);
        check("t1_w6", got[2], 32'hA2);
        check("t1_w7", got[3], 32'hA3);

        // Byte enables on word 5.
        wdata[0] = 32'hFFFFFFFF;
        write_burst(BASE + 32'h14, 4'hF, 8'd0, 1, 1'b1);
        wdata[0] = 32'h12345678;
        write_burst(BASE + 32'h14, 4'b0101, 8'd0, 1, 1'b0);
        read_burst(BASE + 32'h14, 8'd0);
        check("t2_be", got[0], 32'hFF34FF78);

        // Surplus beats are dropped: prefill words 8..10, then a 2-beat burst gets 3 beats.
        wdata[0] = 32'h80; wdata[1] = 32'h81; wdata[2] = 32'h82;
        write_burst(BASE + 32'h20, 4'hF, 8'd2, 3, 1'b1);
        wdata[0] = 32'h11; wdata[1] = 32'h22; wdata[2] = 32'h33;
        write_burst(BASE + 32'h20, 4'hF, 8'd1, 3, 1'b0);
        read_burst(BASE + 32'h20, 8'd2);
        check("drop_w8", got[0], 32'h11);
        check("drop_w9", got[1], 32'h22);
        check("drop_w10", got[2], 32'h82);

        // Top-of-window burst ending exactly on the last word is legal.
        wdata[0] = 32'hC0; wdata[1] = 32'hC1; wdata[2] = 32'hC2; wdata[3] = 32'hC3;
        write_burst(BASE + 32'hFF0, 4'hF, 8'd3, 4, 1'b1);

        // Range error, read: word 1020 + 7 overruns the window.
        begin_txn(BASE + 32'hFF0, 1'b1, 4'hF, 8'd7);
        check("rerr_pulse", {31'd0, busErrorOut}, 32'd1);
        check("rerr_state", {29'd0, debugStateOut}, ST_ERR);
        check("rerr_no_dv1", {31'd0, dataValidOut}, 32'd0);
        tick();
        check("rerr_pulse_off", {31'd0, busErrorOut}, 32'd0);
        check("rerr_end", {31'd0, endTransactionOut}, 32'd1);
        check("rerr_no_dv2", {31'd0, dataValidOut}, 32'd0);
        tick();
        check("rerr_end_off", {31'd0, endTransactionOut}, 32'd0);
        tick();
        check_idle("rerr_idle");

        // Range error, write: stays in ERR until the master ends it.
        begin_txn(BASE + 32'hFF0, 1'b0, 4'hF, 8'd7);
        check("werr_pulse", {31'd0, busErrorOut}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            dataValidIn   = 1'b1;
            addressDataIn = 32'hDEADBEEF;
            tick();
            check("werr_hold_state", {29'd0, debugStateOut}, ST_ERR);
            check("werr_pulse_off", {28'd0, dataValidOut, endTransactionOut, busErrorOut, busyOut}, 32'd0);
        end
        dataValidIn      = 1'b0;
        addressDataIn    = 32'd0;
        endTransactionIn = 1'b1;
        tick();
        endTransactionIn = 1'b0;
        check_idle("werr_idle");
        read_burst(BASE + 32'hFF0, 8'd3);
        check("werr_w1020", got[0], 32'hC0);
        check("werr_w1021", got[1], 32'hC1);
        check("werr_w1022", got[2], 32'hC2);
        check("werr_w1023", got[3], 32'hC3);

        // Address decode: just below and just above the window.
        begin_txn(BASE - 32'd4, 1'b1, 4'hF, 8'd0);
        for (int i = 0; i < 3; i++) begin
            check_idle("dec_below");
            tick();
        end
        begin_txn(BASE + 32'h1000, 1'b0, 4'hF, 8'd0);
        for (int i = 0; i < 3; i++) begin
            dataValidIn   = 1'b1;
            addressDataIn = 32'h55;
            check_idle("dec_above");
            tick();
        end
        dataValidIn   = 1'b0;
        addressDataIn = 32'd0;

        // Reset in the middle of a 16-beat read of words 32..47.
        for (int i = 0; i < 16; i++) wdata[i] = 32'h100 + 32'(i);
        write_burst(BASE + 32'h80, 4'hF, 8'd15, 16, 1'b1);
        begin_txn(BASE + 32'h80, 1'b1, 4'hF, 8'd15);
        k = 0;
        guard = 0;
        while (k < 3 && guard < 50) begin
            tick();
            guard++;
            if (dataValidOut) k++;
        end
        check("rst_reached_beat2", 32'(k), 32'd3);
        check("rst_beat2_data", addressDataOut, 32'h102);
        reset = 1'b0;
        #1;
        check_idle("rst_immediate");
        tick();
        tick();
        reset = 1'b1;
        tick();
        check_idle("rst_released");
        read_burst(BASE + 32'h80, 8'd15);
        check("rst_w32", got[0], 32'h100);
        check("rst_w34", got[2], 32'h102);
        check("rst_w47", got[15], 32'h10F);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
